// File: rtl/bus_xcvr_ctrl.sv
// A-side initiator for an 8-bit bidirectional bus transceiver: generates OE_n/DIR
// with break-before-make turnaround and owns the A-side data drive.
module bus_xcvr_ctrl #(
  parameter int TURN_CYCLES = 1,
  parameter int HOLD_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  input  logic       req_dir,
  input  logic [7:0] req_wdata,
  output logic       req_ready,
  output logic       busy,
  output logic       done,
  output logic [7:0] rd_data,
  output logic       oe_n,
  output logic       dir,
  output logic [7:0] a_out,
  output logic       a_drive,
  input  logic [7:0] a_in
);

  typedef enum logic [1:0] {IDLE, TURN, DRIVE} state_t;

  localparam logic [3:0] TURN_LD = 4'(TURN_CYCLES - 1);
  localparam logic [3:0] HOLD_LD = 4'(HOLD_CYCLES - 1);

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       accept;
  logic       oe_n_nxt, dir_nxt, a_drive_nxt, done_nxt, busy_nxt;
  logic [7:0] a_out_nxt, rd_data_nxt;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // One down-counter serves both the turnaround gap and the drive window.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_dir == dir) begin
            state_nxt = DRIVE;
            cnt_nxt   = HOLD_LD;
          end else begin
            state_nxt = TURN;
            cnt_nxt   = TURN_LD;
          end
        end
      end
      TURN: begin
        if (cnt == 4'd0) begin
          state_nxt = DRIVE;
          cnt_nxt   = HOLD_LD;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      DRIVE: begin
        if (cnt == 4'd0) state_nxt = IDLE;
        else             cnt_nxt   = cnt - 4'd1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered, so this computes their values for the next cycle.
  always_comb begin
    dir_nxt     = accept ? req_dir : dir;
    a_out_nxt   = accept ? req_wdata : a_out;
    oe_n_nxt    = (state_nxt != DRIVE);
    a_drive_nxt = (state_nxt == DRIVE) && dir_nxt;
    busy_nxt    = (state_nxt != IDLE);
    done_nxt    = (state == DRIVE) && (cnt == 4'd0);
    rd_data_nxt = (done_nxt && !dir) ? a_in : rd_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      oe_n    <= 1'b1;
      dir     <= 1'b1;
      a_drive <= 1'b0;
      a_out   <= '0;
      rd_data <= '0;
      done    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      oe_n    <= oe_n_nxt;
      dir     <= dir_nxt;
      a_drive <= a_drive_nxt;
      a_out   <= a_out_nxt;
      rd_data <= rd_data_nxt;
      done    <= done_nxt;
      busy    <= busy_nxt;
    end
  end

  // Break-before-make: DIR may only move while OE_n is high on both sides of the edge.
  always @(posedge clk) begin
    if (!rst && (dir_nxt != dir)) assert (oe_n && oe_n_nxt);
  end

endmodule

// File: tb/tb_bus_xcvr_ctrl.sv
// Directed bench for bus_xcvr_ctrl: default timing instance plus a TURN=3/HOLD=1 instance.
module tb_bus_xcvr_ctrl;

  logic clk, rst;
  logic v0, d0; logic [7:0] w0, ain0;
  logic rdy0, busy0, done0, oe0, dir0, ad0; logic [7:0] rd0, aout0;
  logic v1, d1; logic [7:0] w1, ain1;
  logic rdy1, busy1, done1, oe1, dir1, ad1; logic [7:0] rd1, aout1;

  int n_chk = 0, n_pass = 0;
  int viol_dir = 0, viol_drv = 0;
  logic pdir0, poe0, pdir1, poe1;
  logic wr;

  bus_xcvr_ctrl dut0 (
    .clk(clk), .rst(rst), .req_valid(v0), .req_dir(d0), .req_wdata(w0),
    .req_ready(rdy0), .busy(busy0), .done(done0), .rd_data(rd0), .oe_n(oe0),
    .dir(dir0), .a_out(aout0), .a_drive(ad0), .a_in(ain0)
  );

  bus_xcvr_ctrl #(.TURN_CYCLES(3), .HOLD_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .req_valid(v1), .req_dir(d1), .req_wdata(w1),
    .req_ready(rdy1), .busy(busy1), .done(done1), .rd_data(rd1), .oe_n(oe1),
    .dir(dir1), .a_out(aout1), .a_drive(ad1), .a_in(ain1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Contention / break-before-make watch, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (dir0 != pdir0 && !(oe0 && poe0)) viol_dir++;
      if (dir1 != pdir1 && !(oe1 && poe1)) viol_dir++;
      if (ad0 && !dir0) viol_drv++;
      if (ad1 && !dir1) viol_drv++;
    end
    pdir0 = dir0; poe0 = oe0; pdir1 = dir1; poe1 = oe1;
  end

  initial begin
    rst = 1'b1;
    v0 = 0; d0 = 0; w0 = 0; ain0 = 0;
    v1 = 0; d1 = 0; w1 = 0; ain1 = 0;
    tick(); tick();
    rst = 1'b0;

    // reset state and idle
    chk("rst_oe", oe0, 1); chk("rst_dir", dir0, 1); chk("rst_ad", ad0, 0);
    chk("rst_rd", rd0, 8'h00); chk("rst_rdy", rdy0, 1); chk("rst_busy", busy0, 0);
    chk("rst_aout", aout0, 8'h00);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_done", done0, 0); chk("idle_oe", oe0, 1);
    end

    // same-direction write: no turnaround
    v0 = 1; d0 = 1; w0 = 8'hA5;
    tick();
    v0 = 0;
    chk("wr_e0_oe", oe0, 0); chk("wr_e0_ad", ad0, 1); chk("wr_e0_aout", aout0, 8'hA5);
    chk("wr_e0_busy", busy0, 1); chk("wr_e0_rdy", rdy0, 0); chk("wr_e0_done", done0, 0);
    tick();
    chk("wr_e1_oe", oe0, 0); chk("wr_e1_ad", ad0, 1); chk("wr_e1_done", done0, 0);
    tick();
    chk("wr_e2_done", done0, 1); chk("wr_e2_oe", oe0, 1); chk("wr_e2_ad", ad0, 0);
    chk("wr_e2_dir", dir0, 1); chk("wr_e2_rd", rd0, 8'h00); chk("wr_e2_busy", busy0, 0);
    tick();
    chk("wr_e3_done", done0, 0); chk("wr_e3_aout", aout0, 8'hA5);

    // read after reset: one turnaround cycle
    rst = 1; tick(); rst = 0;
    ain0 = 8'h3C; v0 = 1; d0 = 0; w0 = 8'hFF;
    tick();
    v0 = 0;
    chk("rd_e0_oe", oe0, 1); chk("rd_e0_dir", dir0, 0); chk("rd_e0_ad", ad0, 0);
    chk("rd_e0_busy", busy0, 1);
    tick();
    chk("rd_e1_oe", oe0, 0); chk("rd_e1_ad", ad0, 0);
    tick();
    chk("rd_e2_oe", oe0, 0); chk("rd_e2_done", done0, 0); chk("rd_e2_rd", rd0, 8'h00);
    tick();
    chk("rd_e3_done", done0, 1); chk("rd_e3_rd", rd0, 8'h3C); chk("rd_e3_oe", oe0, 1);

    // back-to-back: read (same dir), then write requested on its done cycle
    tick();
    ain0 = 8'h5A; v0 = 1; d0 = 0;
    tick();
    v0 = 0;
    chk("bb_rd_e0_oe", oe0, 0);
    tick(); tick();
    chk("bb_rd_done", done0, 1); chk("bb_rd_data", rd0, 8'h5A); chk("bb_rdy", rdy0, 1);
    v0 = 1; d0 = 1; w0 = 8'hC3;
    tick();
    v0 = 0;
    chk("bb_wr_e0_dir", dir0, 1); chk("bb_wr_e0_oe", oe0, 1); chk("bb_wr_e0_ad", ad0, 0);
    chk("bb_wr_e0_done", done0, 0);
    tick();
    chk("bb_wr_e1_oe", oe0, 0); chk("bb_wr_e1_ad", ad0, 1); chk("bb_wr_e1_aout", aout0, 8'hC3);
    tick(); tick();
    chk("bb_wr_done", done0, 1); chk("bb_wr_rd_kept", rd0, 8'h5A);

    // reset in the middle of a write's drive window
    tick();
    v0 = 1; d0 = 1; w0 = 8'h77;
    tick();
    v0 = 0;
    chk("mr_drive_oe", oe0, 0);
    #1 rst = 1;
    #1;
    chk("mr_async_oe", oe0, 1); chk("mr_async_ad", ad0, 0); chk("mr_async_busy", busy0, 0);
    chk("mr_async_rd", rd0, 8'h00); chk("mr_async_aout", aout0, 8'h00);
    tick();
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mr_no_done", done0, 0); chk("mr_idle_oe", oe0, 1);
    end
    v0 = 1; d0 = 1; w0 = 8'h11;
    tick();
    v0 = 0;
    chk("mr_wr_e0_oe", oe0, 0); chk("mr_wr_e0_aout", aout0, 8'h11);
    tick(); tick();
    chk("mr_wr_done", done0, 1);

    // TURN=3, HOLD=1 instance: alternate read/write, each a direction change
    tick();
    for (int i = 0; i < 4; i++) begin
      wr = i[0];
      v1 = 1; d1 = wr; w1 = 8'h10 + 8'(i); ain1 = 8'h70 + 8'(i);
      tick();
      v1 = 0;
      chk("t_e0_oe", oe1, 1); chk("t_e0_dir", dir1, wr); chk("t_e0_busy", busy1, 1);
      tick();
      chk("t_e1_oe", oe1, 1);
      tick();
      chk("t_e2_oe", oe1, 1); chk("t_e2_ad", ad1, 0);
      tick();
      chk("t_e3_oe", oe1, 0); chk("t_e3_ad", ad1, wr); chk("t_e3_done", done1, 0);
      tick();
      chk("t_e4_done", done1, 1); chk("t_e4_oe", oe1, 1);
      if (!wr) chk("t_rd_data", rd1, 8'h70 + 8'(i));
      else     chk("t_wr_aout", aout1, 8'h10 + 8'(i));
    end
    tick();
    chk("t_done_drop", done1, 0);
    chk("t_rd_final", rd1, 8'h72);

    chk("dir_break_before_make", viol_dir, 0);
    chk("no_drive_on_read", viol_drv, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/bus_xcvr_ctrl.md
Name: bus_xcvr_ctrl

Overview:
- A-side initiator for the 8-bit bidirectional bus transceiver; it generates the transceiver's OE_n and DIR and owns the A-side data drive.
- Accepts one transfer request at a time: a write (A->B, controller drives A) or a read (B->A, controller samples A).
- Enforces break-before-make: OE_n is always high while DIR changes, followed by a programmable turnaround gap.
- Sits between the CPU control sequencer and the transceiver instance on the main bus.

Parameters:
- TURN_CYCLES, 1, cycles OE_n stays high after a DIR change before driving; legal range 1..15.
- HOLD_CYCLES, 2, cycles OE_n is held low per transfer; legal range 1..15.

Ports:
- clk  input  1  system clock; all state changes on the rising edge
- rst  input  1  asynchronous, active-high reset
- req_valid  input  1  transfer request
- req_dir  input  1  1 = write A->B, 0 = read B->A
- req_wdata  input  8  write data, captured at accept
- req_ready  output  1  combinational; high iff state == IDLE
- busy  output  1  registered; high in TURN or DRIVE
- done  output  1  registered; one-cycle pulse at transfer completion
- rd_data  output  8  registered; last read result
- oe_n  output  1  registered; to transceiver OE_n
- dir  output  1  registered; to transceiver DIR
- a_out  output  8  registered; A-side drive data
- a_drive  output  1  registered; A-side tristate enable
- a_in  input  8  A-side bus value, sampled on reads

Behaviour:
- Reset (async, immediate, including mid-transfer):
  - state = IDLE, oe_n = 1, dir = 1, a_drive = 0, a_out = 0, rd_data = 0, done = 0, busy = 0.
  - No transfer resumes after reset release.
- States: IDLE, TURN, DRIVE. A 4-bit down-counter cnt serves both TURN and DRIVE.
- Accept: at a rising edge with req_valid && req_ready.
  - Latch req_wdata into a_out.
  - Set dir <= req_dir.
  - If req_dir == dir (same direction): go to DRIVE, oe_n <= 0, cnt <= HOLD_CYCLES-1.
  - If req_dir != dir (direction change): go to TURN, oe_n stays 1, cnt <= TURN_CYCLES-1.
- TURN: oe_n = 1, a_drive = 0. When cnt == 0, go to DRIVE, oe_n <= 0, cnt <= HOLD_CYCLES-1. Otherwise cnt decrements.
- DRIVE: oe_n = 0; a_drive = dir.
  - a_drive is never high while dir == 0. This guarantees no A-side contention.
  - On the edge where cnt == 0:
    - oe_n <= 1, a_drive <= 0, done <= 1, state <= IDLE.
    - If dir == 0, rd_data <= a_in, sampled at that same edge.
  - Otherwise cnt decrements.
- Timing:
  - oe_n is low for exactly HOLD_CYCLES cycles per transfer.
  - done rises HOLD_CYCLES edges after accept (same direction) or TURN_CYCLES+HOLD_CYCLES edges after accept (direction change).
- done is high for exactly one cycle. Because req_ready is high during the done cycle, a back-to-back request is accepted on that cycle's edge.
  - Same direction back-to-back: oe_n returns low on the next edge, giving a minimum one-cycle high gap.
- IDLE holds dir at its last value; oe_n = 1; a_drive = 0.
- req_valid is ignored while busy. Requests are never queued; the requester holds req_valid until req_ready.
- rd_data is unchanged by writes. a_out is unchanged outside an accept.
- Invariant, checked by an assertion: dir changes only on edges where oe_n is 1 before and after the edge.

Test Plan:
- Reset, then idle 5 cycles -> oe_n=1, dir=1, a_drive=0, rd_data=0x00, req_ready=1, done never pulses.
- Write req_dir=1, req_wdata=0xA5, defaults -> no TURN; oe_n low and a_drive high with a_out=0xA5 for 2 cycles; done 2 edges after accept; dir stays 1.
- Read req_dir=0 with a_in=0x3C after reset -> oe_n=1 for 1 TURN cycle with dir=0, then 2 cycles oe_n=0 and a_drive=0; done 3 edges after accept; rd_data=0x3C.
- Back-to-back: read then write requested on the done cycle -> write accepted on that edge; dir toggles only while oe_n=1; 1 TURN cycle inserted; a_drive never high while dir=0.
- Reset asserted in the middle of DRIVE of a write -> oe_n=1 and a_drive=0 immediately (asynchronously), no done pulse; first request after release behaves as from reset.
- TURN_CYCLES=3, HOLD_CYCLES=1, alternating read/write 4 times -> each oe_n low for exactly 1 cycle; each preceded by 3 high cycles after a dir change; done 4 edges after each accept.
